// File: rtl/ex_stage_pkg.sv
// Shared definitions for the execute stage: ALU opcodes, EX control bit positions,
// multiplier FSM states and the cycle-count derivation for the iterative multiplier.
package ex_stage_pkg;

    localparam logic [3:0] ALU_OP_ADD   = 4'd0;
    localparam logic [3:0] ALU_OP_SUB   = 4'd1;
    localparam logic [3:0] ALU_OP_AND   = 4'd2;
    localparam logic [3:0] ALU_OP_OR    = 4'd3;
    localparam logic [3:0] ALU_OP_XOR   = 4'd4;
    localparam logic [3:0] ALU_OP_SLL   = 4'd5;
    localparam logic [3:0] ALU_OP_SRL   = 4'd6;
    localparam logic [3:0] ALU_OP_SRA   = 4'd7;
    localparam logic [3:0] ALU_OP_SLT   = 4'd8;
    localparam logic [3:0] ALU_OP_PASSB = 4'd9;
    localparam logic [3:0] ALU_OP_MUL   = 4'd10;

    localparam int CTRL_ALU_SRC = 4;
    localparam int CTRL_BRANCH  = 5;

    typedef enum logic {
        MUL_IDLE = 1'b0,
        MUL_BUSY = 1'b1
    } mul_state_t;

    function automatic int mul_cycles(input int mul_bits);
        return 64 / mul_bits;
    endfunction

endpackage

// File: rtl/ex_mul_iter.sv
// Iterative 64x64 -> low-64 unsigned multiplier retiring MUL_BITS of B per cycle.
// product is combinational (acc + current partial) and valid when last is high.
module ex_mul_iter
    import ex_stage_pkg::*;
#(
    parameter int MUL_BITS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic        busy,
    output logic        last,
    output logic [63:0] product
);

    localparam int MUL_CYCLES = mul_cycles(MUL_BITS);
    localparam int CW         = $clog2(MUL_CYCLES + 1);

    mul_state_t     state;
    logic [CW-1:0]  count;
    logic [63:0]    a_q;
    logic [63:0]    b_q;
    logic [63:0]    acc;
    logic [63:0]    b_chunk;

    // a_q is pre-shifted each cycle, so a_q * chunk already carries the count*MUL_BITS weight
    assign b_chunk = 64'(b_q[MUL_BITS-1:0]);
    assign product = acc + a_q * b_chunk;
    assign busy    = (state == MUL_BUSY);
    assign last    = busy && (count == CW'(MUL_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= MUL_IDLE;
            count <= '0;
            a_q   <= '0;
            b_q   <= '0;
            acc   <= '0;
        end else begin
            case (state)
                MUL_IDLE: begin
                    if (start) begin
                        a_q   <= a;
                        b_q   <= b;
                        acc   <= '0;
                        count <= '0;
                        state <= MUL_BUSY;
                    end
                end
                MUL_BUSY: begin
                    acc   <= product;
                    a_q   <= a_q << MUL_BITS;
                    b_q   <= b_q >> MUL_BITS;
                    count <= count + 1'b1;
                    if (last) begin
                        count <= '0;
                        state <= MUL_IDLE;
                    end
                end
                default: state <= MUL_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU, BEQ resolution, iterative multiply with front-end stall,
// and the EX/MEM pipeline register.
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int MUL_BITS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] EX_reg_data1,
    input  logic [63:0] EX_reg_data2,
    input  logic [63:0] EX_imm,
    input  logic [2:0]  EX_Wreg,
    input  logic [8:0]  EX_addr_ins,
    input  logic [5:0]  EX_EX_CTRL,
    input  logic        EX_MEM_CTRL,
    input  logic [1:0]  EX_WB_CTRL,
    output logic        ex_stall,
    output logic        ex_branch_taken,
    output logic [8:0]  ex_branch_target,
    output logic [63:0] MEM_alu_result,
    output logic [63:0] MEM_store_data,
    output logic [2:0]  MEM_Wreg,
    output logic        MEM_MEM_CTRL,
    output logic [1:0]  MEM_WB_CTRL
);

    logic [3:0]  alu_op;
    logic [63:0] op_b;
    logic [5:0]  shamt;
    logic [63:0] alu_res;
    logic        is_branch;
    logic        mul_start, mul_busy, mul_last;
    logic [63:0] mul_product;

    logic [63:0] lat_store;
    logic [2:0]  lat_wreg;
    logic        lat_mem_ctrl;
    logic [1:0]  lat_wb_ctrl;

    assign alu_op    = EX_EX_CTRL[3:0];
    assign is_branch = EX_EX_CTRL[CTRL_BRANCH];
    assign op_b      = EX_EX_CTRL[CTRL_ALU_SRC] ? EX_imm : EX_reg_data2;
    assign shamt     = op_b[5:0];

    always_comb begin
        alu_res = '0;
        case (alu_op)
            ALU_OP_ADD:   alu_res = EX_reg_data1 + op_b;
            ALU_OP_SUB:   alu_res = EX_reg_data1 - op_b;
            ALU_OP_AND:   alu_res = EX_reg_data1 & op_b;
            ALU_OP_OR:    alu_res = EX_reg_data1 | op_b;
            ALU_OP_XOR:   alu_res = EX_reg_data1 ^ op_b;
            ALU_OP_SLL:   alu_res = EX_reg_data1 << shamt;
            ALU_OP_SRL:   alu_res = EX_reg_data1 >> shamt;
            ALU_OP_SRA:   alu_res = $unsigned($signed(EX_reg_data1) >>> shamt);
            ALU_OP_SLT:   alu_res = {63'd0, $signed(EX_reg_data1) < $signed(op_b)};
            ALU_OP_PASSB: alu_res = op_b;
            default:      alu_res = '0;
        endcase
    end

    // The held MUL on ID/EX must not restart the multiplier once it is busy
    assign mul_start = !mul_busy && (alu_op == ALU_OP_MUL);
    assign ex_stall  = mul_start || (mul_busy && !mul_last);

    assign ex_branch_taken  = is_branch && (EX_reg_data1 == EX_reg_data2) && !mul_busy;
    assign ex_branch_target = EX_addr_ins + EX_imm[8:0];

    ex_mul_iter #(.MUL_BITS(MUL_BITS)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .a       (EX_reg_data1),
        .b       (op_b),
        .busy    (mul_busy),
        .last    (mul_last),
        .product (mul_product)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            lat_store      <= '0;
            lat_wreg       <= '0;
            lat_mem_ctrl   <= 1'b0;
            lat_wb_ctrl    <= '0;
            MEM_alu_result <= '0;
            MEM_store_data <= '0;
            MEM_Wreg       <= '0;
            MEM_MEM_CTRL   <= 1'b0;
            MEM_WB_CTRL    <= '0;
        end else if (mul_start || (mul_busy && !mul_last)) begin
            if (mul_start) begin
                lat_store    <= EX_reg_data2;
                lat_wreg     <= EX_Wreg;
                lat_mem_ctrl <= EX_MEM_CTRL;
                lat_wb_ctrl  <= EX_WB_CTRL;
            end
            MEM_alu_result <= '0;
            MEM_store_data <= '0;
            MEM_Wreg       <= '0;
            MEM_MEM_CTRL   <= 1'b0;
            MEM_WB_CTRL    <= '0;
        end else if (mul_last) begin
            MEM_alu_result <= mul_product;
            MEM_store_data <= lat_store;
            MEM_Wreg       <= lat_wreg;
            MEM_MEM_CTRL   <= lat_mem_ctrl;
            MEM_WB_CTRL    <= lat_wb_ctrl;
        end else begin
            MEM_alu_result <= alu_res;
            MEM_store_data <= EX_reg_data2;
            MEM_Wreg       <= EX_Wreg;
            MEM_MEM_CTRL   <= is_branch ? 1'b0 : EX_MEM_CTRL;
            MEM_WB_CTRL    <= is_branch ? 2'b00 : EX_WB_CTRL;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: expected EX/MEM contents are queued per clock edge
// as instructions are driven and compared after each edge.
module tb_ex_stage;

    localparam int MUL_CYCLES = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] EX_reg_data1, EX_reg_data2, EX_imm;
    logic [2:0]  EX_Wreg;
    logic [8:0]  EX_addr_ins;
    logic [5:0]  EX_EX_CTRL;
    logic        EX_MEM_CTRL;
    logic [1:0]  EX_WB_CTRL;
    logic        ex_stall, ex_branch_taken;
    logic [8:0]  ex_branch_target;
    logic [63:0] MEM_alu_result, MEM_store_data;
    logic [2:0]  MEM_Wreg;
    logic        MEM_MEM_CTRL;
    logic [1:0]  MEM_WB_CTRL;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [63:0] res;
        logic [63:0] sd;
        logic [2:0]  wreg;
        logic        memc;
        logic [1:0]  wb;
    } mem_t;
    mem_t sbq[$];

    always #5 clk = ~clk;

    ex_stage #(.MUL_BITS(4)) dut (
        .clk(clk), .reset(reset),
        .EX_reg_data1(EX_reg_data1), .EX_reg_data2(EX_reg_data2), .EX_imm(EX_imm),
        .EX_Wreg(EX_Wreg), .EX_addr_ins(EX_addr_ins), .EX_EX_CTRL(EX_EX_CTRL),
        .EX_MEM_CTRL(EX_MEM_CTRL), .EX_WB_CTRL(EX_WB_CTRL),
        .ex_stall(ex_stall), .ex_branch_taken(ex_branch_taken),
        .ex_branch_target(ex_branch_target),
        .MEM_alu_result(MEM_alu_result), .MEM_store_data(MEM_store_data),
        .MEM_Wreg(MEM_Wreg), .MEM_MEM_CTRL(MEM_MEM_CTRL), .MEM_WB_CTRL(MEM_WB_CTRL)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [3:0] op, input logic [63:0] a,
                                          input logic [63:0] b);
        logic signed [63:0] sa;
        sa = a;
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return a << b[5:0];
            4'd6:    return a >> b[5:0];
            4'd7:    return sa >>> b[5:0];
            4'd8:    return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
            4'd9:    return b;
            4'd10:   return a * b;
            default: return 64'd0;
        endcase
    endfunction

    task automatic check_mem(input string tag);
        mem_t e;
        if (sbq.size() == 0) begin
            chk({tag, ".sb_underflow"}, 64'd1, 64'd0);
        end else begin
            e = sbq.pop_front();
            chk({tag, ".res"},  MEM_alu_result, e.res);
            chk({tag, ".sd"},   MEM_store_data, e.sd);
            chk({tag, ".wreg"}, 64'(MEM_Wreg), 64'(e.wreg));
            chk({tag, ".memc"}, 64'(MEM_MEM_CTRL), 64'(e.memc));
            chk({tag, ".wb"},   64'(MEM_WB_CTRL), 64'(e.wb));
        end
    endtask

    task automatic set_inputs(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                              input logic [63:0] imm, input logic src, input logic br,
                              input logic [2:0] wreg, input logic memc, input logic [1:0] wb,
                              input logic [8:0] addr);
        EX_reg_data1 = a;
        EX_reg_data2 = b;
        EX_imm       = imm;
        EX_Wreg      = wreg;
        EX_addr_ins  = addr;
        EX_EX_CTRL   = {br, src, op};
        EX_MEM_CTRL  = memc;
        EX_WB_CTRL   = wb;
    endtask

    // Drives one instruction and holds it for as long as the stage stalls
    task automatic drive(input string tag, input logic [3:0] op, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] imm, input logic src,
                         input logic br, input logic [2:0] wreg, input logic memc,
                         input logic [1:0] wb, input logic [8:0] addr);
        logic [63:0] opb;
        mem_t e, bub;
        opb = src ? imm : b;
        bub = '{64'd0, 64'd0, 3'd0, 1'b0, 2'd0};
        @(negedge clk);
        set_inputs(op, a, b, imm, src, br, wreg, memc, wb, addr);
        e = '{model(op, a, opb), b, wreg, br ? 1'b0 : memc, br ? 2'd0 : wb};
        if (op == 4'd10) begin
            for (int k = 0; k <= MUL_CYCLES; k++) begin
                #1;
                chk({tag, ".stall"}, 64'(ex_stall), (k < MUL_CYCLES) ? 64'd1 : 64'd0);
                sbq.push_back((k < MUL_CYCLES) ? bub : e);
                @(posedge clk);
                #1;
                check_mem(tag);
                if (k < MUL_CYCLES) @(negedge clk);
            end
        end else begin
            #1;
            chk({tag, ".stall"}, 64'(ex_stall), 64'd0);
            chk({tag, ".taken"}, 64'(ex_branch_taken), (br && a == b) ? 64'd1 : 64'd0);
            chk({tag, ".target"}, 64'(ex_branch_target), 64'(9'(addr + imm[8:0])));
            sbq.push_back(e);
            @(posedge clk);
            #1;
            check_mem(tag);
        end
    endtask

    initial begin
        reset = 1'b1;
        set_inputs(4'd0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0, 3'd0, 1'b0, 2'd0, 9'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst.res", MEM_alu_result, 64'd0);
        chk("rst.wb", 64'(MEM_WB_CTRL), 64'd0);
        chk("rst.stall", 64'(ex_stall), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        drive("add",  4'd0, 64'd5, 64'd7, 64'd0, 1'b0, 1'b0, 3'd3, 1'b0, 2'b01, 9'd0);
        drive("subi", 4'd1, 64'd10, 64'd99, -64'sd3, 1'b1, 1'b0, 3'd4, 1'b1, 2'b10, 9'd0);
        drive("sra",  4'd7, 64'h8000_0000_0000_0000, 64'd4, 64'd0, 1'b0, 1'b0, 3'd5, 1'b0, 2'b11, 9'd0);
        drive("sll",  4'd5, 64'h1, 64'd0, 64'd63, 1'b1, 1'b0, 3'd1, 1'b0, 2'b01, 9'd0);
        drive("slt",  4'd8, -64'sd2, 64'd1, 64'd0, 1'b0, 1'b0, 3'd2, 1'b0, 2'b01, 9'd0);
        drive("xor",  4'd4, 64'hF0F0, 64'h0FF0, 64'd0, 1'b0, 1'b0, 3'd6, 1'b0, 2'b01, 9'd0);
        drive("op15", 4'd15, 64'd3, 64'd4, 64'd0, 1'b0, 1'b0, 3'd7, 1'b1, 2'b01, 9'd0);
        drive("mul",  4'd10, 64'd3, 64'd5, 64'd0, 1'b0, 1'b0, 3'd2, 1'b0, 2'b01, 9'd0);
        drive("mulw", 4'd10, 64'h8000_0000_0000_0000, 64'd2, 64'd0, 1'b0, 1'b0, 3'd3, 1'b0, 2'b01, 9'd0);
        drive("beq",  4'd1, 64'd9, 64'd9, 64'd5, 1'b0, 1'b1, 3'd1, 1'b1, 2'b11, 9'h010);
        drive("bwrap", 4'd1, 64'd4, 64'd4, 64'd2, 1'b0, 1'b1, 3'd1, 1'b0, 2'b01, 9'h1FF);
        drive("bne",  4'd1, 64'd4, 64'd5, 64'd2, 1'b0, 1'b1, 3'd1, 1'b0, 2'b01, 9'h020);

        // Abandon a multiply mid-flight: no partial result and no lingering stall
        @(negedge clk);
        set_inputs(4'd10, 64'd7, 64'd9, 64'd0, 1'b0, 1'b0, 3'd5, 1'b1, 2'b11, 9'd0);
        repeat (6) @(posedge clk);
        #1;
        chk("rmid.stall", 64'(ex_stall), 64'd1);
        chk("rmid.res", MEM_alu_result, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        set_inputs(4'd0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0, 3'd0, 1'b0, 2'd0, 9'd0);
        @(posedge clk);
        #1;
        chk("rmul.res", MEM_alu_result, 64'd0);
        chk("rmul.wreg", 64'(MEM_Wreg), 64'd0);
        chk("rmul.memc", 64'(MEM_MEM_CTRL), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rmul.stall", 64'(ex_stall), 64'd0);
        for (int i = 0; i < MUL_CYCLES + 2; i++)
            drive("rnop", 4'd0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0, 3'd0, 1'b0, 2'd0, 9'd0);
        drive("radd", 4'd0, 64'd20, 64'd22, 64'd0, 1'b0, 1'b0, 3'd6, 1'b0, 2'b01, 9'd0);

        drive("bb1", 4'd10, 64'h1234_5678, 64'h9ABC_DEF0_1357, 64'd0, 1'b0, 1'b0, 3'd1, 1'b0, 2'b01, 9'd0);
        drive("bb2", 4'd10, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd11, 1'b1, 1'b0, 3'd2, 1'b0, 2'b10, 9'd0);
        drive("bb3", 4'd0, 64'd1, 64'd2, 64'd0, 1'b0, 1'b0, 3'd3, 1'b1, 2'b01, 9'd0);

        chk("sb_empty", 64'(sbq.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
